rr_request_encoder_8to3: RTL and testbench
==========================================

# rr_request_encoder_8to3

Sequential 8-to-3 encoder: the inverse of the 3-to-8 select decoder in the RAM32x8 structural FIFO. It collects one-hot or multi-hot request pulses from eight sources into a pending register and issues them one at a time as a 3-bit binary index. Issue order is round-robin, and each index is offered on a valid/ready handshake. It feeds word-line or bank select indices back into the decoder path of the structural RAM/FIFO.

## Interface
- PTR_INIT, 0: reset value of the round-robin pointer, range 0..7.
- Clk  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- Req  input  8  request pulses; bit i high for one cycle sets pending bit i.
- Ready  input  1  consumer accepts Index when Ready && Valid at a rising edge.
- Index  output  3  binary index of the offered request; registered.
- Valid  output  1  Index holds an offered request; registered.
- Pending  output  8  current pending register, for status and debug.

## Operation
- Reset values: Pending=8'h00, Valid=0, Index=3'd0, Ptr=PTR_INIT.
- Pending update each cycle: Pending <= (Pending & ~Clr) | Req.
  - Clr is one-hot(Index) when Valid && Ready, else 0.
  - If the accepted bit is also set in Req in the same cycle, the set wins and the bit stays pending.
- Pick function: the first set bit of a candidate vector, scanning circularly from Ptr upward (Ptr, Ptr+1, …, 7, 0, …, Ptr-1). Index arithmetic is mod 8, using 3-bit wrap.
- FSM with two states:
  - IDLE (Valid=0): if Pending != 0, load Index = pick(Pending) and go to OFFER. Otherwise stay. Req arriving this cycle is not visible to pick.
  - OFFER (Valid=1): Index and Valid hold while Ready=0.
  - On acceptance (Ready=1): Ptr <= Index+1. Let Rem = Pending & ~one-hot(Index).
    - If Rem != 0, load Index = pick(Rem) with Ptr' = Index+1 and stay in OFFER, giving a back-to-back issue.
    - Otherwise go to IDLE.
- Ready while Valid=0 is ignored.
- Duplicate Req on a bit that is already pending is absorbed. There is no counting and no overflow flag.
- Ptr changes only on acceptance.

## Timing
- Request-to-offer latency: Req high at edge n → Pending bit set after edge n → Valid=1 and Index valid after edge n+1. This is 2 cycles from an empty, idle state.
- Throughput: one index per cycle while Ready=1 and requests remain.
- After the last acceptance, Valid drops on the next edge.
  - A request arriving in that same acceptance cycle is offered 2 cycles later, via IDLE.
- Reset asserted mid-operation drops Valid and Pending asynchronously in the same cycle. The first offer after release follows the 2-cycle latency rule with Ptr=PTR_INIT.
- Outputs are glitch-free: all are registers, with no combinational path from Req or Ready to any output.

## Structure
- Shared package:
  - IDX_W=3, N_REQ=8.
  - State enum {IDLE, OFFER}.
  - Function onehot3(idx) → 8-bit.
- Sub-module `rr_priority_pick8`: purely combinational; inputs vector[7:0] and ptr[2:0]; outputs idx[2:0] and any.
  - Instantiated once, with input muxed between Pending (IDLE) and Rem (OFFER).
- Top module holds the Pending register, Ptr, Index/Valid registers and the FSM.

## Test plan
- Reset then Req=8'h01 for one cycle, Ready=1 → Valid=1, Index=0 two cycles after the Req edge; Valid=0 the next cycle; Pending=0.
- Req=8'hA4 for one cycle, Ready=1, PTR_INIT=0 → indices 2,5,7 on three consecutive cycles, then Valid=0.
- Req=8'h81, Ready=0 for 5 cycles → Index=0, Valid=1 held stable. Raise Ready → 0 then 7 issued back-to-back.
- Wrap-around: after accepting 6, set Req=8'h41 → next issues 0 then 6 (circular scan from Ptr=7).
- Set-wins: while Index=3 is accepted (Ready=1), pulse Req=8'h08 → Pending[3] remains 1 and 3 is offered again.
- Async reset asserted while Valid=1 with Pending=8'hF0 → Valid=0, Pending=0, Index=0 before the next clock edge; Ptr=PTR_INIT.

Source files
------------

// File: rtl/rr_request_encoder_8to3_pkg.sv
// Shared widths, FSM state type and one-hot helper for the round-robin
// 8-to-3 request encoder.
package rr_request_encoder_8to3_pkg;

    localparam int IDX_W = 3;
    localparam int N_REQ = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot3(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_request_encoder_8to3_pick.sv
// Combinational circular priority pick: first set bit of i_vector scanning
// upward from i_ptr with 3-bit wrap.
module rr_priority_pick8
    import rr_request_encoder_8to3_pkg::*;
(
    input  logic [N_REQ-1:0] i_vector,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_off;

    // Descending scan so the smallest offset from i_ptr wins.
    always_comb begin
        w_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_vector[i_ptr + IDX_W'(k)]) begin
                w_off = IDX_W'(k);
            end
        end
        o_any = |i_vector;
        o_idx = i_ptr + w_off;
    end

endmodule

// File: rtl/rr_request_encoder_8to3.sv
// Collects request pulses into a pending register and issues them one at a
// time as a registered 3-bit index on a valid/ready handshake, round-robin.
module rr_request_encoder_8to3
    import rr_request_encoder_8to3_pkg::*;
#(
    parameter int PTR_INIT = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_ready,
    output logic [IDX_W-1:0] o_index,
    output logic             o_valid,
    output logic [N_REQ-1:0] o_pending,
    output state_t           o_state,
    output logic [IDX_W-1:0] o_ptr
);

    // Handshake: an index transfers on a rising edge where o_valid && i_ready;
    // o_index/o_valid hold while i_ready is low, and i_ready is ignored
    // while o_valid is low.

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_index;
    logic [IDX_W-1:0] w_index_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [N_REQ-1:0] r_pending;

    logic             w_accept;
    logic [N_REQ-1:0] w_clr;
    logic [N_REQ-1:0] w_rem;
    logic [N_REQ-1:0] w_pick_vec;
    logic [IDX_W-1:0] w_pick_ptr;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_any;

    assign w_accept = r_valid && i_ready;
    assign w_clr    = w_accept ? onehot3(r_index) : '0;
    assign w_rem    = r_pending & ~onehot3(r_index);

    // While offering, the next pick looks past the index being accepted.
    assign w_pick_vec = (r_state == IDLE) ? r_pending : w_rem;
    assign w_pick_ptr = (r_state == IDLE) ? r_ptr : r_index + 1'b1;

    rr_priority_pick8 u_pick (
        .i_vector (w_pick_vec),
        .i_ptr    (w_pick_ptr),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_valid_nxt = r_valid;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_index_nxt = w_pick_idx;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (i_ready) begin
                    w_ptr_nxt = r_index + 1'b1;
                    if (w_pick_any) begin
                        w_index_nxt = w_pick_idx;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_index   <= '0;
            r_valid   <= 1'b0;
            r_ptr     <= IDX_W'(PTR_INIT);
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_index   <= w_index_nxt;
            r_valid   <= w_valid_nxt;
            r_ptr     <= w_ptr_nxt;
            // A request on the bit being accepted re-arms it.
            r_pending <= (r_pending & ~w_clr) | i_req;
        end
    end

    assign o_index   = r_index;
    assign o_valid   = r_valid;
    assign o_pending = r_pending;
    assign o_state   = r_state;
    assign o_ptr     = r_ptr;

endmodule

// File: tb/tb_rr_request_encoder_8to3.sv
// Directed bench for rr_request_encoder_8to3: expected issue order queued at
// stimulus time, popped and compared at every accepted handshake.
module tb_rr_request_encoder_8to3;
  import rr_request_encoder_8to3_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req = 8'h00;
  logic       ready = 1'b0;
  logic [2:0] index;
  logic       valid;
  logic [7:0] pending;
  state_t     state;
  logic [2:0] ptr;

  int num_tests = 0;
  int num_fail  = 0;
  logic [7:0] exp_q[$];

  rr_request_encoder_8to3 #(.PTR_INIT(0)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req),
    .i_ready   (ready),
    .o_index   (index),
    .o_valid   (valid),
    .o_pending (pending),
    .o_state   (state),
    .o_ptr     (ptr)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    num_tests++;
    assert (obs === exp) else begin
      num_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: a handshake visible now transfers at the next edge.
  task automatic tick();
    logic [7:0] e;
    if (valid && ready) begin
      check("accept_expected", 8'(exp_q.size() != 0), 8'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("accept_index", 8'(index), e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic [7:0] r);
    req = r;
    tick();
    req = 8'h00;
  endtask

  task automatic idle_gap();
    int n;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 8'(valid), 8'd0);
    check("rst_index", 8'(index), 8'd0);
    check("rst_pending", pending, 8'h00);
    check("rst_ptr", 8'(ptr), 8'd0);
    check("rst_state", 8'(state), 8'(IDLE));
    rst = 1'b0;
    tick();

    // single request, 2-cycle latency
    ready = 1'b1;
    exp_q.push_back(8'd0);
    pulse_req(8'h01);
    check("t1_pending_set", pending, 8'h01);
    check("t1_valid_early", 8'(valid), 8'd0);
    tick();
    check("t1_valid", 8'(valid), 8'd1);
    check("t1_index", 8'(index), 8'd0);
    tick();
    check("t1_valid_drop", 8'(valid), 8'd0);
    check("t1_pending_clr", pending, 8'h00);
    check("t1_ptr", 8'(ptr), 8'd1);
    idle_gap();

    // multi-hot, back-to-back issue 2,5,7
    exp_q.push_back(8'd2);
    exp_q.push_back(8'd5);
    exp_q.push_back(8'd7);
    pulse_req(8'hA4);
    tick();
    check("t2_first", 8'(index), 8'd2);
    tick();
    check("t2_second", 8'(index), 8'd5);
    check("t2_valid_b2b", 8'(valid), 8'd1);
    tick();
    check("t2_third", 8'(index), 8'd7);
    tick();
    check("t2_valid_drop", 8'(valid), 8'd0);
    check("t2_ptr_wrap", 8'(ptr), 8'd0);
    idle_gap();

    // backpressure hold then drain 0,7
    ready = 1'b0;
    pulse_req(8'h81);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 8'(valid), 8'd1);
      check("t3_hold_index", 8'(index), 8'd0);
      check("t3_hold_ptr", 8'(ptr), 8'd0);
      tick();
    end
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd7);
    ready = 1'b1;
    tick();
    check("t3_next", 8'(index), 8'd7);
    tick();
    check("t3_valid_drop", 8'(valid), 8'd0);
    check("t3_pending", pending, 8'h00);
    idle_gap();

    // wrap-around: accept 6 so ptr=7, then 8'h41 issues 0 then 6
    exp_q.push_back(8'd6);
    pulse_req(8'h40);
    tick();
    tick();
    check("t4_ptr7", 8'(ptr), 8'd7);
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd6);
    pulse_req(8'h41);
    tick();
    check("t4_first", 8'(index), 8'd0);
    tick();
    check("t4_second", 8'(index), 8'd6);
    tick();
    check("t4_valid_drop", 8'(valid), 8'd0);
    check("t4_ptr", 8'(ptr), 8'd7);
    idle_gap();

    // set-wins on the accepted bit
    ready = 1'b0;
    exp_q.push_back(8'd3);
    pulse_req(8'h08);
    tick();
    check("t5_offer", 8'(index), 8'd3);
    ready = 1'b1;
    exp_q.push_back(8'd3);
    pulse_req(8'h08);
    check("t5_pending_kept", pending, 8'h08);
    check("t5_valid_idle", 8'(valid), 8'd0);
    tick();
    check("t5_reoffer_valid", 8'(valid), 8'd1);
    check("t5_reoffer_index", 8'(index), 8'd3);
    tick();
    check("t5_valid_drop", 8'(valid), 8'd0);
    check("t5_pending_clr", pending, 8'h00);
    check("t5_ptr", 8'(ptr), 8'd4);

    // async reset while offering
    ready = 1'b0;
    pulse_req(8'hF0);
    tick();
    check("t6_pre_valid", 8'(valid), 8'd1);
    check("t6_pre_index", 8'(index), 8'd4);
    check("t6_pre_pending", pending, 8'hF0);
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 8'(valid), 8'd0);
    check("t6_rst_pending", pending, 8'h00);
    check("t6_rst_index", 8'(index), 8'd0);
    check("t6_rst_ptr", 8'(ptr), 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // post-reset latency with ptr back at PTR_INIT
    ready = 1'b1;
    exp_q.push_back(8'd4);
    exp_q.push_back(8'd7);
    pulse_req(8'h90);
    check("t7_valid_early", 8'(valid), 8'd0);
    tick();
    check("t7_first", 8'(index), 8'd4);
    tick();
    check("t7_second", 8'(index), 8'd7);
    tick();
    check("t7_valid_drop", 8'(valid), 8'd0);
    check("t7_state", 8'(state), 8'(IDLE));

    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", num_tests, num_fail);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
